ts_hex_formatter: RTL and testbench

Converts a binary timestamp word into a fixed-length ASCII hex line and streams it one byte at a time into the UART transmitter's `tx_valid`/`tx_data`/`tx_ready` byte interface. It sits between the timestamp capture logic and `uart_tx`. Each accepted timestamp produces one line: NIBBLES uppercase hex digits, most-significant digit first, followed by CR LF. It holds the line in an internal shift register, so the producer is free as soon as the word is accepted.

---
 rtl/ts_hex_formatter.sv | 104 ++++++++++
 tb/tb_ts_hex_formatter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ts_hex_formatter.sv
// Formats a TS_BITS-wide timestamp as uppercase ASCII hex followed by CR LF and streams it
// byte by byte on a valid/ready interface. Optional macro TS_FMT_PREFIX_EN prepends "0x".
module ts_hex_formatter #(
  parameter int TS_BITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ts_valid,
  input  logic [TS_BITS-1:0] ts_data,
  output logic               ts_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic               busy
);

  localparam int NIBBLES = TS_BITS / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NIBBLES - 1);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
  // Once tx_valid is raised, tx_data is held until that transfer.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef TS_FMT_PREFIX_EN
    S_PFX0  = 3'd1,
    S_PFX1  = 3'd2,
`endif
    S_DIGIT = 3'd3,
    S_CR    = 3'd4,
    S_LF    = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [TS_BITS-1:0] sr_q, sr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         top_nib;

  assign top_nib  = sr_q[TS_BITS-1 -: 4];
  assign ts_ready = (state_q == S_IDLE);
  assign tx_valid = (state_q != S_IDLE);
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    tx_data = 8'h00;
    case (state_q)
`ifdef TS_FMT_PREFIX_EN
      S_PFX0:  tx_data = 8'h30;
      S_PFX1:  tx_data = 8'h78;
`endif
      S_DIGIT: tx_data = (top_nib <= 4'd9) ? (8'h30 + {4'h0, top_nib})
                                           : (8'h37 + {4'h0, top_nib});
      S_CR:    tx_data = 8'h0D;
      S_LF:    tx_data = 8'h0A;
      default: tx_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ts_valid) begin
          sr_d  = ts_data;
          cnt_d = '0;
`ifdef TS_FMT_PREFIX_EN
          state_d = S_PFX0;
`else
          state_d = S_DIGIT;
`endif
        end
      end
`ifdef TS_FMT_PREFIX_EN
      S_PFX0: if (tx_ready) state_d = S_PFX1;
      S_PFX1: if (tx_ready) state_d = S_DIGIT;
`endif
      S_DIGIT: begin
        if (tx_ready) begin
          sr_d  = {sr_q[TS_BITS-5:0], 4'h0};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_DIGIT) state_d = S_CR;
        end
      end
      S_CR:    if (tx_ready) state_d = S_LF;
      S_LF:    if (tx_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ts_hex_formatter.sv
// Bench for ts_hex_formatter: directed lines, backpressure, reset mid-line and random words,
// checked by a byte scoreboard fed from a string-level reference model.
module tb_ts_hex_formatter;

  localparam int W = 32;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ts_valid;
  logic [W-1:0] ts_data;
  logic         ts_ready;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic         tx_ready;
  logic         busy;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;
  int line_pops = 0;
  logic [7:0] exp_q[$];

  ts_hex_formatter #(.TS_BITS(W)) dut (
    .clk(clk), .rst(rst), .ts_valid(ts_valid), .ts_data(ts_data), .ts_ready(ts_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] hex_char(input int v);
    if (v < 10) return 8'(48 + v);
    return 8'(65 + v - 10);
  endfunction

  task automatic push_line(input logic [W-1:0] w);
    longint unsigned val;
    int nib;
    val = longint'(w);
`ifdef TS_FMT_PREFIX_EN
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h78);
`endif
    for (int i = N - 1; i >= 0; i--) begin
      nib = int'((val / (64'd1 << (4 * i))) % 16);
      exp_q.push_back(hex_char(nib));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // ---------------- tx_ready driver ----------------
  initial begin
    int cyc;
    cyc = 0;
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = ((cyc % 16) == 0);
        2: tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic       hold;
    logic [7:0] hold_data;
    logic       expect_idle;
    logic [7:0] exp;
    hold = 1'b0;
    hold_data = 8'h00;
    expect_idle = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        hold = 1'b0;
        expect_idle = 1'b0;
        line_pops = 0;
      end else begin
        if (exp_q.size() > 0)
          check("in_line_valid_busy_notready", {29'd0, tx_valid, busy, ts_ready}, 32'b110);
        if (expect_idle) begin
          check("idle_after_lf", {29'd0, tx_valid, busy, ts_ready}, 32'b001);
          expect_idle = 1'b0;
        end
        if (hold) begin
          check("hold_valid", {31'd0, tx_valid}, 32'd1);
          check("hold_data", {24'd0, tx_data}, {24'd0, hold_data});
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
          end else begin
            exp = exp_q.pop_front();
            check("byte", {24'd0, tx_data}, {24'd0, exp});
            line_pops++;
            if (exp_q.size() == 0) expect_idle = 1'b1;
          end
        end
        if (ts_valid && ts_ready) begin
          push_line(ts_data);
          line_pops = 0;
        end
        hold = tx_valid && !tx_ready;
        hold_data = tx_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] w);
    int n;
    ts_data = w;
    ts_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (ts_ready) break;
      n++;
      if (n > 3000) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    ts_valid = 1'b0;
    ts_data = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 || busy) begin
      @(negedge clk);
      n++;
      if (n > 4000) begin
        check("drain_timeout", 32'd0, 32'd1);
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string name);
    check(name, {20'd0, tx_data, 1'b0, tx_valid, busy, ts_ready}, 32'b001);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1;
    ts_valid = 1'b0;
    ts_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_check("reset_values");
    rst = 1'b0;
    @(posedge clk);
    #1;

    ready_mode = 0;
    send(32'hDEADBEEF);
    drain();

    ready_mode = 1;
    send(32'hDEADBEEF);
    drain();

    ready_mode = 0;
    send(32'hCAFEF00D);
    send(32'h01234567);
    drain();

    send(32'h00000000);
    send(32'hFFFFFFFF);
    send(32'h9A9A9A9A);
    drain();

    send(32'h12345678);
    n = 0;
    while (line_pops < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_third_byte", {31'd0, line_pops >= 3}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    reset_check("midline_reset");
    rst = 1'b0;
    send(32'h0000000F);
    drain();

    ready_mode = 2;
    for (int i = 0; i < 20; i++) begin
      send(W'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();
    check("queue_empty_at_end", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
